hub75_capture: RTL and testbench
================================

# hub75_capture

Receive-side model of the HUB75 panel interface. Samples the panel-facing signals (led_clk, led_latch, led_output_enable, addr, rgb0, rgb1) with clk_in, reconstructs each shifted row-pair line, and presents it downstream as one record on a valid/ready handshake. Used in loopback against hub75_output, both on-chip and on the bench, to check pixel ordering, line length and blanking without a physical panel.

## Interface
- NUM_COLS, 64, pixels shifted per line (per rgb lane)
- SCAN_RATE, 32, row-pair addresses; addr width is $clog2(SCAN_RATE)
- CNT_W, $clog2(NUM_COLS)+1, width of pixel counter
- clk_in  input  1  capture clock; must be ≥ 4× hub75 led_clk frequency
- rst_in_n  input  1  asynchronous, active-low reset
- hub_clk  input  1  HUB75 shift clock
- hub_latch  input  1  HUB75 latch (active-high)
- hub_oe_n  input  1  HUB75 output enable (active-low)
- hub_addr  input  $clog2(SCAN_RATE)  row-pair address
- hub_rgb0  input  3  upper-half pixel bits
- hub_rgb1  input  3  lower-half pixel bits
- line_valid  output  1  line record available
- line_ready  input  1  downstream accepts record
- line_addr  output  $clog2(SCAN_RATE)  hub_addr captured at latch
- line_rgb0  output  3*NUM_COLS  upper-half pixels; column c at bits [3c+2:3c]
- line_rgb1  output  3*NUM_COLS  lower-half pixels, same packing
- line_count  output  CNT_W  shift edges seen in this line (saturates at NUM_COLS+1)
- line_short  output  1  line_count < NUM_COLS
- line_long  output  1  more than NUM_COLS shifts seen
- overrun  output  1  sticky: a latched line was dropped
- oe_err  output  1  sticky: latch while outputs enabled (see Configuration)

## Operation
- All hub_* inputs pass through the same 2-FF synchronizer, then one registered stage for edge detection; relative alignment between signals is preserved.
- Rising edge of synchronized hub_clk: shift synchronized rgb0/rgb1 into the working line. Shift-register semantics: after the line completes, the k-th shifted pixel (k=0 first) sits at column NUM_COLS-1-k. Counter increments and saturates at NUM_COLS+1. Shifts beyond NUM_COLS keep shifting (oldest pixels fall off) and set long.
- Rising edge of synchronized hub_latch: snapshot working line, count, addr and short/long into the output register, then clear the working count to 0. Working pixel contents are not cleared.
- The same cycle sees a clk edge and a latch edge: the shift is applied first and included in the snapshot.
- States: IDLE (line_valid=0) and HOLD (line_valid=1). IDLE→HOLD on latch edge. HOLD→IDLE on line_valid&&line_ready with no latch edge. Latch edge in HOLD with line_ready=1: new record replaces old and stays in HOLD (back-to-back, no bubble). Latch edge in HOLD with line_ready=0: new line dropped, record unchanged, overrun set.
- Outputs are stable while line_valid=1 and line_ready=0.
- Latch with zero shifts: emits a record with line_count=0 and line_short=1.
- overrun and oe_err clear only on reset.

## Timing
- Reset (async assert, deassert synchronized internally): line_valid=0, line_addr=0, line_rgb0/1=0, line_count=0, line_short=0, line_long=0, overrun=0, oe_err=0, state IDLE, working count 0. Reset mid-line discards the partial line.
- Latency: if the first clk_in edge sampling hub_latch high is cycle 0, line_valid is high at cycle 3.
- A hub_clk edge must have rgb stable for ≥ 2 clk_in cycles on both sides of it. Each hub_clk/hub_latch high and low phase must last ≥ 2 clk_in cycles; otherwise behaviour is undefined.
- Handshake: transfer happens on the clk_in edge with line_valid&&line_ready. line_valid never depends combinationally on line_ready.

## Configuration
- HUB75_CAPTURE_OE_CHECK_EN defined: on a latch edge with synchronized hub_oe_n=0, set oe_err (sticky). The line is still captured.
- Not defined: no OE check logic; oe_err tied to 0; hub_oe_n unused.

## Test plan
- Shift 64 pixels, rgb0=k[2:0], rgb1=~k[2:0], then latch with addr=5 → one record: addr=5, count=64, short=0, long=0, column 63 rgb0=0, column 0 rgb0=3'b111 (k=63).
- 60 shifts then latch → count=60, short=1. 70 shifts then latch → count=65 (saturated), long=1, columns hold the last 64 pixels.
- line_ready=0; two latched lines (addr 1, then 2) → record stays at addr 1, overrun=1. Raise ready → one transfer, then line_valid=0.
- line_ready=1 constantly; 32 lines, addr 0..31, back-to-back → 32 transfers in order; overrun stays 0.
- With HUB75_CAPTURE_OE_CHECK_EN: latch with hub_oe_n=0 → oe_err=1 and record still emitted. Without the macro, same stimulus → oe_err=0.
- Assert rst_in_n low after 30 shifts, release, then 64 shifts and latch → count=64; all outputs are at reset values during reset.

Source files
------------

// File: rtl/hub75_capture.sv
// hub75_capture: samples HUB75 panel signals on clk_in, rebuilds each latched row-pair line
// and offers it downstream as one record on valid/ready. Optional OE check: HUB75_CAPTURE_OE_CHECK_EN.
module hub75_capture #(
    parameter int NUM_COLS  = 64,
    parameter int SCAN_RATE = 32,
    parameter int CNT_W     = $clog2(NUM_COLS) + 1
) (
    input  logic                         clk_in,
    input  logic                         rst_in_n,
    input  logic                         hub_clk,
    input  logic                         hub_latch,
    input  logic                         hub_oe_n,
    input  logic [$clog2(SCAN_RATE)-1:0] hub_addr,
    input  logic [2:0]                   hub_rgb0,
    input  logic [2:0]                   hub_rgb1,
    output logic                         line_valid,
    input  logic                         line_ready,
    output logic [$clog2(SCAN_RATE)-1:0] line_addr,
    output logic [3*NUM_COLS-1:0]        line_rgb0,
    output logic [3*NUM_COLS-1:0]        line_rgb1,
    output logic [CNT_W-1:0]             line_count,
    output logic                         line_short,
    output logic                         line_long,
    output logic                         overrun,
    output logic                         oe_err
);
    localparam int ADDR_W = $clog2(SCAN_RATE);
    localparam int LINE_W = 3 * NUM_COLS;
    localparam int SYNC_W = ADDR_W + 9;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_COLS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(NUM_COLS + 1);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [1:0]        rst_sync_r;
    logic              rst_n_s;
    logic [SYNC_W-1:0] raw_s;
    logic [SYNC_W-1:0] sync1_r;
    logic [SYNC_W-1:0] sync2_r;
    logic              hub_clk_d_r;
    logic              hub_latch_d_r;
    logic              s_clk;
    logic              s_latch;
    logic              s_oe_n;
    logic [ADDR_W-1:0] s_addr;
    logic [2:0]        s_rgb0;
    logic [2:0]        s_rgb1;
    logic              clk_rise_s;
    logic              latch_rise_s;

    logic [LINE_W-1:0] work0_r;
    logic [LINE_W-1:0] work1_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [LINE_W-1:0] work0_next_s;
    logic [LINE_W-1:0] work1_next_s;
    logic [CNT_W-1:0]  cnt_next_s;

    logic [0:0]        state_r;
    logic [0:0]        state_next_s;
    logic              load_s;
    logic              drop_s;
    logic              overrun_r;

    // Reset asserts asynchronously but releases two clk_in edges later
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end
    assign rst_n_s = rst_sync_r[1];

    assign raw_s = {hub_clk, hub_latch, hub_oe_n, hub_addr, hub_rgb0, hub_rgb1};

    // All panel signals share one synchronizer so their relative alignment survives
    always_ff @(posedge clk_in or negedge rst_n_s) begin
        if (!rst_n_s) begin
            sync1_r       <= {SYNC_W{1'b0}};
            sync2_r       <= {SYNC_W{1'b0}};
            hub_clk_d_r   <= 1'b0;
            hub_latch_d_r <= 1'b0;
        end else begin
            sync1_r       <= raw_s;
            sync2_r       <= sync1_r;
            hub_clk_d_r   <= sync2_r[SYNC_W-1];
            hub_latch_d_r <= sync2_r[SYNC_W-2];
        end
    end

    assign s_clk        = sync2_r[SYNC_W-1];
    assign s_latch      = sync2_r[SYNC_W-2];
    assign s_oe_n       = sync2_r[SYNC_W-3];
    assign s_addr       = sync2_r[6 +: ADDR_W];
    assign s_rgb0       = sync2_r[5:3];
    assign s_rgb1       = sync2_r[2:0];
    assign clk_rise_s   = s_clk & ~hub_clk_d_r;
    assign latch_rise_s = s_latch & ~hub_latch_d_r;

    // Working line after this cycle's shift; the snapshot uses these so a coincident shift is included
    always_comb begin
        work0_next_s = work0_r;
        work1_next_s = work1_r;
        cnt_next_s   = cnt_r;
        if (clk_rise_s) begin
            work0_next_s = {work0_r[LINE_W-4:0], s_rgb0};
            work1_next_s = {work1_r[LINE_W-4:0], s_rgb1};
            if (cnt_r != CNT_SAT) begin
                cnt_next_s = cnt_r + CNT_W'(1);
            end else begin
                cnt_next_s = cnt_r;
            end
        end else begin
            work0_next_s = work0_r;
            work1_next_s = work1_r;
            cnt_next_s   = cnt_r;
        end
    end

    // Working shift register and per-line shift counter; pixels persist across latches
    always_ff @(posedge clk_in or negedge rst_n_s) begin
        if (!rst_n_s) begin
            work0_r <= {LINE_W{1'b0}};
            work1_r <= {LINE_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            work0_r <= work0_next_s;
            work1_r <= work1_next_s;
            if (latch_rise_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_next_s;
            end
        end
    end

    // Handshake control: a latch in HOLD only replaces the record if it is being taken this cycle
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        drop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (latch_rise_s) begin
                    load_s       = 1'b1;
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (latch_rise_s) begin
                    if (line_ready) begin
                        load_s = 1'b1;
                    end else begin
                        drop_s = 1'b1;
                    end
                    state_next_s = ST_HOLD;
                end else if (line_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State and sticky overrun
    always_ff @(posedge clk_in or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r   <= ST_IDLE;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            overrun_r <= overrun_r | drop_s;
        end
    end

    // Output record register, only written on an accepted latch
    always_ff @(posedge clk_in or negedge rst_n_s) begin
        if (!rst_n_s) begin
            line_addr  <= {ADDR_W{1'b0}};
            line_rgb0  <= {LINE_W{1'b0}};
            line_rgb1  <= {LINE_W{1'b0}};
            line_count <= {CNT_W{1'b0}};
            line_short <= 1'b0;
            line_long  <= 1'b0;
        end else if (load_s) begin
            line_addr  <= s_addr;
            line_rgb0  <= work0_next_s;
            line_rgb1  <= work1_next_s;
            line_count <= cnt_next_s;
            line_short <= (cnt_next_s < CNT_FULL);
            line_long  <= (cnt_next_s > CNT_FULL);
        end else begin
            line_addr  <= line_addr;
            line_rgb0  <= line_rgb0;
            line_rgb1  <= line_rgb1;
            line_count <= line_count;
            line_short <= line_short;
            line_long  <= line_long;
        end
    end

    assign line_valid = (state_r == ST_HOLD);
    assign overrun    = overrun_r;

`ifdef HUB75_CAPTURE_OE_CHECK_EN
    logic oe_err_r;

    // Latching while the panel is lit is flagged but the line is still captured
    always_ff @(posedge clk_in or negedge rst_n_s) begin
        if (!rst_n_s) begin
            oe_err_r <= 1'b0;
        end else if (latch_rise_s && !s_oe_n) begin
            oe_err_r <= 1'b1;
        end else begin
            oe_err_r <= oe_err_r;
        end
    end
    assign oe_err = oe_err_r;
`else
    logic unused_oe_s;
    assign unused_oe_s = s_oe_n;
    assign oe_err      = 1'b0;
`endif

endmodule

// File: tb/tb_hub75_capture.sv
// Bench for hub75_capture: drives HUB75 lines with random pixels and checks each emitted
// record against a pixel-history model of the panel shift register.
module tb_hub75_capture;
    localparam int NC = 64;
    localparam int LW = 3 * NC;

    typedef struct packed {
        logic [4:0]    addr;
        logic [LW-1:0] rgb0;
        logic [LW-1:0] rgb1;
        logic [6:0]    count;
        logic          shrt;
        logic          lng;
    } rec_t;

    logic          clk_in = 1'b0;
    logic          rst_in_n;
    logic          hub_clk;
    logic          hub_latch;
    logic          hub_oe_n;
    logic [4:0]    hub_addr;
    logic [2:0]    hub_rgb0;
    logic [2:0]    hub_rgb1;
    logic          line_valid;
    logic          line_ready;
    logic [4:0]    line_addr;
    logic [LW-1:0] line_rgb0;
    logic [LW-1:0] line_rgb1;
    logic [6:0]    line_count;
    logic          line_short;
    logic          line_long;
    logic          overrun;
    logic          oe_err;

    rec_t       exp_q[$];
    logic [2:0] hist0[$];
    logic [2:0] hist1[$];
    rec_t       mon_e;
    rec_t       held;
    int         vectors     = 0;
    int         miscompares = 0;
    int         transfers   = 0;
    int         xfer_base;
    logic       exp_oe;

    hub75_capture dut (
        .clk_in     (clk_in),
        .rst_in_n   (rst_in_n),
        .hub_clk    (hub_clk),
        .hub_latch  (hub_latch),
        .hub_oe_n   (hub_oe_n),
        .hub_addr   (hub_addr),
        .hub_rgb0   (hub_rgb0),
        .hub_rgb1   (hub_rgb1),
        .line_valid (line_valid),
        .line_ready (line_ready),
        .line_addr  (line_addr),
        .line_rgb0  (line_rgb0),
        .line_rgb1  (line_rgb1),
        .line_count (line_count),
        .line_short (line_short),
        .line_long  (line_long),
        .overrun    (overrun),
        .oe_err     (oe_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected record: column c holds the (c+1)-th most recent pixel ever shifted since reset
    function automatic rec_t predict(input logic [4:0] a, input int n);
        rec_t r;
        int   len;
        int   k;
        r      = '0;
        r.addr = a;
        len    = hist0.size();
        for (int c = 0; c < NC; c++) begin
            k = len - 1 - c;
            if (k >= 0) begin
                r.rgb0[3*c +: 3] = hist0[k];
                r.rgb1[3*c +: 3] = hist1[k];
            end
        end
        r.count = (n > NC + 1) ? 7'(NC + 1) : 7'(n);
        r.shrt  = (n < NC);
        r.lng   = (n > NC);
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic pixels(input int n, input bit pattern);
        logic [31:0] kv;
        logic [2:0]  p0;
        logic [2:0]  p1;
        for (int k = 0; k < n; k++) begin
            kv = k;
            if (pattern) begin
                p0 = kv[2:0];
                p1 = ~kv[2:0];
            end else begin
                p0 = 3'($urandom_range(0, 7));
                p1 = 3'($urandom_range(0, 7));
            end
            hub_rgb0 = p0;
            hub_rgb1 = p1;
            hist0.push_back(p0);
            hist1.push_back(p1);
            tick(3);
            hub_clk = 1'b1;
            tick(3);
            hub_clk = 1'b0;
        end
    endtask

    task automatic send_line(input logic [4:0] a, input int n, input bit accept, input logic oe_n);
        hub_addr = a;
        hub_oe_n = oe_n;
        pixels(n, 1'b0);
        tick(3);
        if (accept) exp_q.push_back(predict(a, n));
        hub_latch = 1'b1;
        tick(3);
        hub_latch = 1'b0;
        tick(3);
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0) break;
            tick(1);
        end
        check("drain_pending", LW'(exp_q.size()), LW'(0));
        tick(2);
        check("valid_after_drain", line_valid, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, line_valid, 1'b0);
        check({tag, "_addr"}, line_addr, 5'd0);
        check({tag, "_rgb0"}, line_rgb0, {LW{1'b0}});
        check({tag, "_rgb1"}, line_rgb1, {LW{1'b0}});
        check({tag, "_count"}, line_count, 7'd0);
        check({tag, "_short"}, line_short, 1'b0);
        check({tag, "_long"}, line_long, 1'b0);
        check({tag, "_overrun"}, overrun, 1'b0);
        check({tag, "_oe_err"}, oe_err, 1'b0);
    endtask

    // Every accepted record is compared with the oldest outstanding prediction
    always @(negedge clk_in) begin
        if (rst_in_n && line_valid && line_ready) begin
            transfers++;
            if (exp_q.size() == 0) begin
                check("spurious_xfer", line_valid, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check("xfer_addr", line_addr, mon_e.addr);
                check("xfer_rgb0", line_rgb0, mon_e.rgb0);
                check("xfer_rgb1", line_rgb1, mon_e.rgb1);
                check("xfer_count", line_count, mon_e.count);
                check("xfer_short", line_short, mon_e.shrt);
                check("xfer_long", line_long, mon_e.lng);
            end
        end
    end

    initial begin
`ifdef HUB75_CAPTURE_OE_CHECK_EN
        exp_oe = 1'b1;
`else
        exp_oe = 1'b0;
`endif
        rst_in_n   = 1'b0;
        hub_clk    = 1'b0;
        hub_latch  = 1'b0;
        hub_oe_n   = 1'b1;
        hub_addr   = 5'd0;
        hub_rgb0   = 3'd0;
        hub_rgb1   = 3'd0;
        line_ready = 1'b0;
        tick(3);
        check_reset_outputs("por");
        rst_in_n = 1'b1;
        tick(5);

        // Full 64-pixel patterned line, held with ready low to observe latency
        hub_addr = 5'd5;
        pixels(NC, 1'b1);
        tick(3);
        exp_q.push_back(predict(5'd5, NC));
        hub_latch = 1'b1;
        tick(2);
        check("latency_not_yet", line_valid, 1'b0);
        tick(2);
        check("latency_valid", line_valid, 1'b1);
        tick(2);
        hub_latch = 1'b0;
        tick(3);
        held = line_rgb0;
        check("col0_rgb0", held[2:0], 3'b111);
        check("col63_rgb0", held[LW-1 -: 3], 3'b000);
        check("full_count", line_count, 7'd64);
        check("full_addr", line_addr, 5'd5);
        line_ready = 1'b1;
        drain();

        // Short and long lines
        send_line(5'd7, 60, 1'b1, 1'b1);
        send_line(5'd8, 70, 1'b1, 1'b1);
        drain();

        // Back-to-back lines with ready held high, first one with no shifts
        xfer_base = transfers;
        for (int a = 0; a < 32; a++) begin
            send_line(5'(a), (a == 0) ? 0 : int'($urandom_range(0, 6)), 1'b1, 1'b1);
        end
        drain();
        check("b2b_transfers", LW'(transfers - xfer_base), LW'(32));
        check("b2b_overrun", overrun, 1'b0);
        check("oe_clean", oe_err, 1'b0);

        // Overrun: second line latched while the first is still held
        line_ready = 1'b0;
        send_line(5'd1, 5, 1'b1, 1'b1);
        held = exp_q[0];
        check("ovr_valid", line_valid, 1'b1);
        check("ovr_first_addr", line_addr, 5'd1);
        check("ovr_not_yet", overrun, 1'b0);
        send_line(5'd2, 3, 1'b0, 1'b1);
        check("ovr_held_addr", line_addr, 5'd1);
        check("ovr_held_rgb0", line_rgb0, held.rgb0);
        check("ovr_held_count", line_count, held.count);
        check("ovr_flag", overrun, 1'b1);
        xfer_base  = transfers;
        line_ready = 1'b1;
        drain();
        check("ovr_one_xfer", LW'(transfers - xfer_base), LW'(1));

        // Latch while outputs are enabled
        send_line(5'd3, 10, 1'b1, 1'b0);
        drain();
        hub_oe_n = 1'b1;
        check("oe_err", oe_err, exp_oe);

        // Reset in the middle of a line, then a clean full line
        pixels(30, 1'b0);
        tick(2);
        rst_in_n = 1'b0;
        tick(2);
        check_reset_outputs("mid_rst");
        hist0.delete();
        hist1.delete();
        exp_q.delete();
        rst_in_n = 1'b1;
        tick(5);
        send_line(5'd9, NC, 1'b1, 1'b1);
        drain();
        check("post_rst_overrun", overrun, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
